// File: rtl/simd_pkg.sv
// Shared types for the SIMD sequencer: opcodes, sequencer states and the
// instruction word layout.
package simd_pkg;

    localparam int unsigned OPCODE_WIDTH   = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_MUL  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_MAX  = 4'h7,
        OP_MIN  = 4'h8,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_DRAIN
    } seq_state_t;

    // Decoded low bits of an instruction word at the default data address width.
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]   opcode;
        logic [DEF_ADDR_WIDTH-1:0] r_addr;
        logic [DEF_ADDR_WIDTH-1:0] b_addr;
        logic [DEF_ADDR_WIDTH-1:0] a_addr;
    } instr_t;

endpackage

// File: rtl/wb_delay_line.sv
// Write-back alignment shift register carrying {wen, r_addr}; flush clears
// every stage so no queued write can reach BRAM R.
module wb_delay_line #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_wen,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_wen,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  pending
);

    logic [DEPTH-1:0]      wen_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else if (flush) begin
            wen_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            wen_q[0]  <= in_wen;
            addr_q[0] <= in_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                wen_q[i]  <= wen_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_wen  = wen_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];
    assign pending  = |wen_q;

endmodule

// File: rtl/simd_sequencer.sv
// Program sequencer for the SIMD datapath: fetches instructions from the
// instruction BRAM, issues A/B reads and delays the R write to match the PEs.
module simd_sequencer
    import simd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned INS_ADDR_WIDTH = 8,
    parameter int unsigned INS_WIDTH      = 64,
    parameter int unsigned PE_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [INS_ADDR_WIDTH-1:0] start_pc,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err_no_halt,
    output logic [INS_ADDR_WIDTH-1:0] pc,
    input  logic [INS_WIDTH-1:0]      ins_rdata,
    output logic [OPCODE_WIDTH-1:0]   opcode,
    output logic                      issue_valid,
    output logic [ADDR_WIDTH-1:0]     bram_a_addr,
    output logic [ADDR_WIDTH-1:0]     bram_b_addr,
    output logic [ADDR_WIDTH-1:0]     bram_r_addr,
    output logic                      bram_r_wen
);

    localparam int unsigned WB_LAT         = 1 + PE_LATENCY;
    localparam int unsigned INS_DATA_WIDTH = 3 * ADDR_WIDTH + OPCODE_WIDTH;
    localparam logic [INS_ADDR_WIDTH-1:0] PC_ONE = {{(INS_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [ADDR_WIDTH-1:0]   r_addr;
        logic [ADDR_WIDTH-1:0]   b_addr;
        logic [ADDR_WIDTH-1:0]   a_addr;
    } ins_fields_t;

    ins_fields_t ins;
    assign ins = ins_fields_t'(ins_rdata[INS_DATA_WIDTH-1:0]);

    generate
        if (INS_WIDTH > INS_DATA_WIDTH) begin : g_ins_hi
            logic unused_ins_hi;
            assign unused_ins_hi = ^ins_rdata[INS_WIDTH-1:INS_DATA_WIDTH];
        end
    endgenerate

    seq_state_t state, state_next;

    // ins_addr tracks the address of the word on ins_rdata; pc saturates at
    // the top of memory so it cannot be used to recover that address.
    logic [INS_ADDR_WIDTH-1:0] ins_addr;
    logic [INS_ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0]     r_addr_q;
    logic                      issue_wen;
    logic                      wb_pending;
    logic                      do_start, do_fetch, do_issue, do_finish, do_abort;
    logic                      at_last_addr;

    assign pc_inc       = (&pc) ? pc : pc + PC_ONE;
    assign at_last_addr = &ins_addr;
    assign issue_wen    = issue_valid && (opcode != OP_NOP);

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_fetch   = 1'b0;
        do_issue   = 1'b0;
        do_finish  = 1'b0;
        do_abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    do_start   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                do_fetch   = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (ins.opcode == OP_HALT) begin
                    state_next = S_DRAIN;
                end else begin
                    do_issue = 1'b1;
                    if (at_last_addr) state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!issue_wen && !wb_pending) begin
                    do_finish  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            do_fetch   = 1'b0;
            do_issue   = 1'b0;
            do_finish  = 1'b0;
            do_abort   = 1'b1;
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            ins_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_no_halt <= 1'b0;
            issue_valid <= 1'b0;
            opcode      <= '0;
            bram_a_addr <= '0;
            bram_b_addr <= '0;
            r_addr_q    <= '0;
        end else begin
            issue_valid <= do_issue;
            if (do_start) begin
                pc          <= start_pc;
                busy        <= 1'b1;
                done        <= 1'b0;
                err_no_halt <= 1'b0;
            end
            if (do_fetch) begin
                ins_addr <= pc;
                pc       <= pc_inc;
            end
            if (do_issue) begin
                opcode      <= ins.opcode;
                bram_a_addr <= ins.a_addr;
                bram_b_addr <= ins.b_addr;
                r_addr_q    <= ins.r_addr;
                ins_addr    <= pc;
                pc          <= pc_inc;
                if (at_last_addr) err_no_halt <= 1'b1;
            end
            if (do_finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (do_abort) busy <= 1'b0;
        end
    end

    wb_delay_line #(
        .DEPTH      (WB_LAT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wb_delay (
        .clk      (clk),
        .rst      (rst),
        .flush    (do_abort),
        .in_wen   (issue_wen),
        .in_addr  (r_addr_q),
        .out_wen  (bram_r_wen),
        .out_addr (bram_r_addr),
        .pending  (wb_pending)
    );

endmodule

// File: tb/tb_simd_sequencer.sv
// Self-checking bench for simd_sequencer: instruction BRAM model plus a
// program-level reference model of issue, write-back and completion timing.
module tb_simd_sequencer;
    import simd_pkg::*;

    localparam int AW  = 10;
    localparam int IAW = 8;
    localparam int IW  = 64;
    localparam int PEL = 2;
    localparam int WB  = 1 + PEL;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [IAW-1:0] start_pc = '0;
    logic           abort = 1'b0;
    logic           busy, done, err_no_halt;
    logic [IAW-1:0] pc;
    logic [IW-1:0]  ins_rdata = '0;
    logic [3:0]     opcode;
    logic           issue_valid;
    logic [AW-1:0]  bram_a_addr, bram_b_addr, bram_r_addr;
    logic           bram_r_wen;

    logic [IW-1:0] imem [256];

    int n_cmp = 0;
    int n_bad = 0;

    simd_sequencer #(
        .ADDR_WIDTH     (AW),
        .INS_ADDR_WIDTH (IAW),
        .INS_WIDTH      (IW),
        .PE_LATENCY     (PEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err_no_halt (err_no_halt),
        .pc          (pc),
        .ins_rdata   (ins_rdata),
        .opcode      (opcode),
        .issue_valid (issue_valid),
        .bram_a_addr (bram_a_addr),
        .bram_b_addr (bram_b_addr),
        .bram_r_addr (bram_r_addr),
        .bram_r_wen  (bram_r_wen)
    );

    always #5 clk = ~clk;

    // Instruction BRAM: synchronous read, one cycle of latency.
    always @(posedge clk) ins_rdata <= imem[pc];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [9:0] a,
                                       input logic [9:0] b, input logic [9:0] r,
                                       input logic [29:0] hi);
        return {hi, op, r, b, a};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_no_halt, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_opcode"}, opcode, 0);
        chk({tag, "_issue_valid"}, issue_valid, 0);
        chk({tag, "_a_addr"}, bram_a_addr, 0);
        chk({tag, "_b_addr"}, bram_b_addr, 0);
        chk({tag, "_r_addr"}, bram_r_addr, 0);
        chk({tag, "_r_wen"}, bram_r_wen, 0);
    endtask

    // Runs one program from spc. ab: sample index at which the abort edge has
    // taken effect (-1 none). bs: sample at which a stray start is driven.
    // rs: sample after which reset is asserted asynchronously.
    task automatic run(input logic [7:0] spc, input int ab_in, input int bs, input int rs,
                       output int done_j, output int first_wen_j, output int last_wen_j,
                       output int wen_cnt, output int iv_cnt);
        logic [63:0] words[$];
        logic [63:0] w;
        bit          halted;
        int          addr, n, last_wr, entry, dr, jmax, ab, jj, pcv, k;
        bit          exp_iv, exp_wen, exp_busy, exp_done, exp_err;

        halted = 0;
        addr   = spc;
        while (1) begin
            w = imem[addr];
            if (w[33:30] == 4'hF) begin
                halted = 1;
                break;
            end
            words.push_back(w);
            if (addr == 255) break;
            addr++;
        end
        n = words.size();
        last_wr = -100;
        for (int i = 0; i < n; i++)
            if (words[i][33:30] != 4'h0) last_wr = 2 + i + WB;
        entry = halted ? 2 + n : 1 + n;
        dr = (entry + 1 > last_wr + 2) ? entry + 1 : last_wr + 2;
        ab = (ab_in >= dr) ? -1 : ab_in;
        jmax = (ab >= 0) ? ab + 3 : ((rs >= 0) ? rs : dr + 1);

        done_j = -1; first_wen_j = -1; last_wen_j = -1; wen_cnt = 0; iv_cnt = 0;

        @(negedge clk);
        start = 1'b1;
        start_pc = spc;
        if (ab == 0) abort = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= jmax; j++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            start_pc = IAW'($urandom);
            if (ab >= 0 && j >= ab) begin
                jj = ab - 1;
                exp_iv = 0; exp_wen = 0; exp_busy = 0; exp_done = 0;
            end else begin
                jj = j;
                exp_iv = (j >= 2 && j < 2 + n);
                k = j - 2 - WB;
                exp_wen = (k >= 0 && k < n) ? (words[k][33:30] != 4'h0) : 1'b0;
                exp_busy = (j < dr);
                exp_done = (j >= dr);
            end
            exp_err = !halted && (jj >= n + 1);
            pcv = spc + ((jj < n + 1) ? jj : n + 1);
            if (pcv > 255) pcv = 255;

            chk("issue_valid", issue_valid, exp_iv);
            if (exp_iv) begin
                chk("opcode", opcode, words[j-2][33:30]);
                chk("a_addr", bram_a_addr, words[j-2][9:0]);
                chk("b_addr", bram_b_addr, words[j-2][19:10]);
            end
            chk("r_wen", bram_r_wen, exp_wen);
            if (exp_wen) chk("r_addr", bram_r_addr, words[j-2-WB][29:20]);
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("err_no_halt", err_no_halt, exp_err);
            chk("pc", pc, pcv);

            if (issue_valid) iv_cnt++;
            if (bram_r_wen) begin
                wen_cnt++;
                if (first_wen_j < 0) first_wen_j = j;
                last_wen_j = j;
            end
            if (done && done_j < 0) done_j = j;

            if (j == bs) begin
                start = 1'b1;
                start_pc = spc ^ 8'h5A;
            end
            if (ab >= 0 && j == ab - 1) abort = 1'b1;
            if (j == rs) begin
                #1 rst = 1'b1;
                #1 check_all_zero("async_rst");
                break;
            end
        end
    endtask

    initial begin
        int dj, fw, lw, wc, ivc;
        for (int i = 0; i < 256; i++) imem[i] = mk(OP_HALT, 0, 0, 0, 0);

        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;

        // Three ADDs then HALT at 0
        for (int i = 0; i < 3; i++)
            imem[i] = mk(OP_ADD, 10'(i + 1), 10'(i + 1), 10'(10 + i), 0);
        imem[3] = mk(OP_HALT, 0, 0, 0, 0);
        run(8'd0, -1, -1, -1, dj, fw, lw, wc, ivc);
        chk("t1_first_wen", fw, 5);
        chk("t1_last_wen", lw, 7);
        chk("t1_wen_cnt", wc, 3);
        chk("t1_done_at", dj, 9);
        chk("t1_err", err_no_halt, 0);

        // HALT at the first address
        imem[8] = mk(OP_HALT, 0, 0, 0, 0);
        run(8'd8, -1, -1, -1, dj, fw, lw, wc, ivc);
        chk("t2_done_at", dj, 3);
        chk("t2_issue_cnt", ivc, 0);
        chk("t2_wen_cnt", wc, 0);

        // NOP between two ADDs
        imem[16] = mk(OP_ADD, 10'd5, 10'd6, 10'd100, 0);
        imem[17] = mk(OP_NOP, 10'd7, 10'd8, 10'd101, 0);
        imem[18] = mk(OP_SUB, 10'd9, 10'd10, 10'd102, 0);
        imem[19] = mk(OP_HALT, 0, 0, 0, 0);
        run(8'd16, -1, -1, -1, dj, fw, lw, wc, ivc);
        chk("t3_issue_cnt", ivc, 3);
        chk("t3_wen_cnt", wc, 2);
        chk("t3_first_wen", fw, 5);
        chk("t3_last_wen", lw, 7);

        // Runs off the end of instruction memory
        imem[254] = mk(OP_ADD, 10'd1, 10'd2, 10'd300, 0);
        imem[255] = mk(OP_MUL, 10'd3, 10'd4, 10'd301, 0);
        run(8'd254, -1, -1, -1, dj, fw, lw, wc, ivc);
        chk("t4_err", err_no_halt, 1);
        chk("t4_done", done, 1);
        chk("t4_pc", pc, 255);
        chk("t4_issue_cnt", ivc, 2);

        // Abort two cycles into a ten-instruction program, then rerun cleanly
        for (int i = 0; i < 10; i++)
            imem[32+i] = mk(OP_XOR, 10'(i), 10'(i + 50), 10'(200 + i), 0);
        imem[42] = mk(OP_HALT, 0, 0, 0, 0);
        run(8'd32, 4, -1, -1, dj, fw, lw, wc, ivc);
        chk("t5_wen_cnt", wc, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        run(8'd0, -1, -1, -1, dj, fw, lw, wc, ivc);
        chk("t5_rerun_done_at", dj, 9);
        chk("t5_rerun_wen_cnt", wc, 3);

        // Stray start while busy, then async reset in DRAIN
        run(8'd0, -1, 3, 7, dj, fw, lw, wc, ivc);
        @(negedge clk);
        check_all_zero("after_rst_edge");
        rst = 1'b0;
        run(8'd16, -1, -1, -1, dj, fw, lw, wc, ivc);
        chk("t6_post_rst_wen_cnt", wc, 2);

        // Randomised programs, occasionally near the top of memory or aborted
        for (int t = 0; t < 40; t++) begin
            int len, spc, ab;
            spc = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 200);
            len = $urandom_range(0, 12);
            for (int i = 0; i < len && spc + i < 256; i++)
                imem[spc+i] = mk(4'($urandom_range(0, 8)), 10'($urandom), 10'($urandom),
                                 10'($urandom), 30'($urandom));
            if (spc + len < 256)
                imem[spc+len] = ($urandom_range(0, 4) != 0)
                    ? mk(OP_HALT, 10'($urandom), 10'($urandom), 10'($urandom), 30'($urandom))
                    : mk(OP_ADD, 10'($urandom), 10'($urandom), 10'($urandom), 30'($urandom));
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 4) : -1;
            run(8'(spc), ab, -1, -1, dj, fw, lw, wc, ivc);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
